// File: rtl/hawk_axi_rd_arb_pkg.sv
// hawk_rd_pkg: shared types and constants for the hawk AXI read arbiter.
//   rd_arb_state_e  - arbiter FSM states (IDLE / ADDR / DATA)
//   RD_REQ_*        - requester index assignments
//   AXI_*           - fixed AR channel encodings
//   idxWidth/rrWrap - helpers for sizing requester indices and round-robin walks
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif

package hawk_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_arb_state_e;

  localparam int RD_REQ_PGMNGR  = 0;
  localparam int RD_REQ_CMPMNGR = 1;

  // Full 64-byte cacheline beats, incrementing bursts.
  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // A single requester still needs a one-bit index field.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rrWrap(input int unsigned base,
                                         input int unsigned off,
                                         input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/hawk_axi_rd_arb_if.sv
// hawk_axi_rd_if: AXI4 read-only bus (AR + R channels).
//   master modport - drives m_araddr/m_arlen/m_arsize/m_arburst/m_arvalid and
//                    m_rready; observes m_arready and the R channel.
//   slave modport  - the mirror image, used by the memory side / testbench.
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif

interface hawk_axi_rd_if #(
  parameter int AW = `HACD_AXI4_ADDR_WIDTH,
  parameter int DW = `HACD_AXI4_DATA_WIDTH
) ();

  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_arvalid;
  logic          m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          m_rvalid;
  logic          m_rready;

  modport master (
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

endinterface

// File: rtl/hawk_axi_rd_arb_rr.sv
// hawk_rr_arb: combinational round-robin picker.
//   req_i   - request vector, one bit per requester
//   ptr_i   - index that gets first chance this round
//   grant_o - one-hot winner (all zero when nobody requests)
//   idx_o   - binary index of the winner (zero when nobody requests)
module hawk_rr_arb
  import hawk_rd_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o
);

  logic          found;
  logic [IW-1:0] cand;

  // Walk the requesters starting at ptr_i and wrapping; the first one asking wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'(rrWrap(32'(ptr_i), i, NUM_REQ));
      if (!found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hawk_axi_rd_arb.sv
// hawk_axi_rd_arb: shares one AXI read port between NUM_REQ requesters,
// one burst outstanding at a time.
//   clk_i, rst_i        - clock, synchronous active-high reset
//   req_vld_i/addr/len  - per-requester read request (held until accepted)
//   req_acc_o           - one-cycle accept pulse to the winner
//   rsp_vld_o           - per-requester beat valid
//   rsp_data_o/last/err - shared response beat; err only on the last beat
//   busy_o              - high while a burst is being issued or drained
//   m_axi               - AXI AR/R channels (master side)
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif

module hawk_axi_rd_arb
  import hawk_rd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = `HACD_AXI4_ADDR_WIDTH,
  parameter int DW      = `HACD_AXI4_DATA_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQ-1:0]    req_vld_i,
  input  logic [NUM_REQ*AW-1:0] req_addr_i,
  input  logic [NUM_REQ*8-1:0]  req_len_i,
  output logic [NUM_REQ-1:0]    req_acc_o,
  output logic [NUM_REQ-1:0]    rsp_vld_o,
  output logic [DW-1:0]         rsp_data_o,
  output logic                  rsp_last_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  hawk_axi_rd_if.master         m_axi
);

  localparam int IW = idxWidth(NUM_REQ);

  rd_arb_state_e        state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           count_q, count_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rrPtr_q, rrPtr_d;
  logic                 sticky_q, sticky_d;
  logic [NUM_REQ-1:0]   winGrant;
  logic [IW-1:0]        winIdx;

  hawk_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req_i   (req_vld_i),
    .ptr_i   (rrPtr_q),
    .grant_o (winGrant),
    .idx_o   (winIdx)
  );

  // State and latched-transaction registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      count_q  <= '0;
      owner_q  <= '0;
      rrPtr_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      count_q  <= count_d;
      owner_q  <= owner_d;
      rrPtr_q  <= rrPtr_d;
      sticky_q <= sticky_d;
    end
  end

  // Next-state: accept in IDLE, hand off on AR handshake, drain R until rlast.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    count_d  = count_q;
    owner_d  = owner_q;
    rrPtr_d  = rrPtr_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (|req_vld_i) begin
          state_d  = ADDR;
          owner_d  = winIdx;
          count_d  = '0;
          sticky_d = 1'b0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (winIdx == IW'(i)) begin
              addr_d = req_addr_i[i*AW +: AW];
              len_d  = req_len_i[i*8 +: 8];
            end
          end
        end
      end
      ADDR: begin
        if (m_axi.m_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (m_axi.m_rvalid) begin
          count_d = count_q + 8'd1;
          if (m_axi.m_rresp[1]) begin
            sticky_d = 1'b1;
          end
          if (m_axi.m_rlast) begin
            state_d = IDLE;
            rrPtr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          end else if (count_q >= len_q) begin
            // Slave overran the burst length; remember it for the real last beat.
            sticky_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: accept pulse, AR payload, and combinational R pass-through.
  always_comb begin
    req_acc_o         = '0;
    rsp_vld_o         = '0;
    rsp_data_o        = '0;
    rsp_last_o        = 1'b0;
    rsp_err_o         = 1'b0;
    busy_o            = (state_q != IDLE);
    m_axi.m_araddr    = '0;
    m_axi.m_arlen     = '0;
    m_axi.m_arsize    = '0;
    m_axi.m_arburst   = '0;
    m_axi.m_arvalid   = 1'b0;
    m_axi.m_rready    = 1'b0;
    case (state_q)
      IDLE: begin
        // An accept during reset would be lost, so hold it off.
        if (!rst_i) begin
          req_acc_o = winGrant;
        end
      end
      ADDR: begin
        m_axi.m_arvalid = 1'b1;
        m_axi.m_araddr  = addr_q;
        m_axi.m_arlen   = len_q;
        m_axi.m_arsize  = AXI_SIZE_64B;
        m_axi.m_arburst = AXI_BURST_INCR;
      end
      DATA: begin
        m_axi.m_rready = 1'b1;
        if (m_axi.m_rvalid) begin
          rsp_vld_o[owner_q] = 1'b1;
          rsp_data_o         = m_axi.m_rdata;
          rsp_last_o         = m_axi.m_rlast;
          rsp_err_o          = m_axi.m_rlast &&
                               (sticky_q || m_axi.m_rresp[1] || (count_q != len_q));
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// tb_hawk_axi_rd_arb: directed bench for hawk_axi_rd_arb with a transaction-level
// reference model checked every cycle plus hand-computed literal checks.
module tb_hawk_axi_rd_arb;

  localparam int AW = 64;
  localparam int DW = 512;

  localparam logic [AW-1:0] ADDR0 = 64'h0000_0000_8000_0040;
  localparam logic [AW-1:0] ADDR1 = 64'h0000_0000_9000_0080;
  localparam logic [7:0]    LEN0  = 8'd0;
  localparam logic [7:0]    LEN1  = 8'd3;

  logic            clk;
  logic            rst;
  logic [1:0]      reqVld;
  logic [2*AW-1:0] reqAddr;
  logic [15:0]     reqLen;
  logic [1:0]      reqAcc;
  logic [1:0]      rspVld;
  logic [DW-1:0]   rspData;
  logic            rspLast;
  logic            rspErr;
  logic            busy;

  int nVectors     = 0;
  int nMiscompares = 0;

  hawk_axi_rd_if #(.AW(AW), .DW(DW)) axi ();

  hawk_axi_rd_arb #(.NUM_REQ(2), .AW(AW), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_vld_i  (reqVld),
    .req_addr_i (reqAddr),
    .req_len_i  (reqLen),
    .req_acc_o  (reqAcc),
    .rsp_vld_o  (rspVld),
    .rsp_data_o (rspData),
    .rsp_last_o (rspLast),
    .rsp_err_o  (rspErr),
    .busy_o     (busy),
    .m_axi      (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared comparison: counts every check, reports any difference.
  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [1:0] vld, input logic arRdy,
                               input logic rVal, input logic rLst,
                               input logic [1:0] rRsp, input logic [DW-1:0] rDat);
    @(posedge clk);
    #1;
    rst            = r;
    reqVld         = vld;
    axi.m_arready  = arRdy;
    axi.m_rvalid   = rVal;
    axi.m_rlast    = rLst;
    axi.m_rresp    = rRsp;
    axi.m_rdata    = rDat;
  endtask

  function automatic logic [DW-1:0] mkData(input int n);
    logic [63:0] w;
    w = 64'hC0DE_0000_0000_0000 ^ 64'(n);
    return {8{w}};
  endfunction

  // ---------------- reference model (transaction level) ----------------
  bit          modelValid = 1'b0;
  bit          mBusy, mArPend, mBad;
  int          mOwner, mLen, mBeats, mPtr;
  logic [AW-1:0] mAddr;

  function automatic int pickWinner(input logic [1:0] vld, input int ptr);
    for (int k = 0; k < 2; k++) begin
      if (vld[(ptr + k) % 2]) return (ptr + k) % 2;
    end
    return -1;
  endfunction

  // Advance the model with the inputs the DUT sees at this edge.
  always @(posedge clk) begin
    int w;
    if (rst) begin
      mBusy = 0; mArPend = 0; mBad = 0; mPtr = 0; mBeats = 0; mOwner = 0;
      mLen = 0; mAddr = '0; modelValid = 1'b1;
    end else if (modelValid) begin
      if (!mBusy) begin
        w = pickWinner(reqVld, mPtr);
        if (w >= 0) begin
          mBusy = 1; mArPend = 1; mOwner = w; mBeats = 0; mBad = 0;
          mAddr = reqAddr[w*AW +: AW];
          mLen  = int'(reqLen[w*8 +: 8]);
        end
      end else if (mArPend) begin
        if (axi.m_arready) mArPend = 0;
      end else if (axi.m_rvalid) begin
        if (axi.m_rresp[1]) mBad = 1;
        mBeats++;
        if (axi.m_rlast) begin
          mBusy = 0;
          mPtr  = (mOwner + 1) % 2;
        end else if (mBeats > mLen) begin
          mBad = 1;
        end
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (modelValid) begin
      int            w;
      logic [1:0]    eAcc, eVld;
      logic [DW-1:0] eData;
      logic          eLast, eErr, beat, inAr, inR;
      eAcc = '0; eVld = '0; eData = '0; eLast = 0; eErr = 0;
      inAr = mBusy && mArPend;
      inR  = mBusy && !mArPend;
      beat = inR && axi.m_rvalid;
      if (!mBusy && !rst) begin
        w = pickWinner(reqVld, mPtr);
        if (w >= 0) eAcc[w] = 1'b1;
      end
      if (beat) begin
        eVld[mOwner] = 1'b1;
        eData = axi.m_rdata;
        eLast = axi.m_rlast;
        eErr  = axi.m_rlast && (mBad || axi.m_rresp[1] || (mBeats != mLen));
      end
      checkOutput("req_acc_o",  reqAcc,  eAcc);
      checkOutput("busy_o",     busy,    mBusy);
      checkOutput("m_arvalid",  axi.m_arvalid, inAr);
      checkOutput("m_araddr",   axi.m_araddr,  inAr ? mAddr : '0);
      checkOutput("m_arlen",    axi.m_arlen,   inAr ? 8'(mLen) : 8'd0);
      checkOutput("m_arsize",   axi.m_arsize,  inAr ? 3'b110 : 3'b000);
      checkOutput("m_arburst",  axi.m_arburst, inAr ? 2'b01 : 2'b00);
      checkOutput("m_rready",   axi.m_rready,  inR);
      checkOutput("rsp_vld_o",  rspVld,  eVld);
      checkOutput("rsp_data_o", rspData, eData);
      checkOutput("rsp_last_o", rspLast, eLast);
      checkOutput("rsp_err_o",  rspErr,  eErr);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed sequence with literal expectations ----------------
  initial begin
    rst = 1'b1; reqVld = '0;
    reqAddr = {ADDR1, ADDR0};
    reqLen  = {LEN1, LEN0};
    axi.m_arready = 0; axi.m_rvalid = 0; axi.m_rlast = 0;
    axi.m_rresp = '0; axi.m_rdata = '0;
    applyStimulus(1, 2'b00, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit reset busy", busy, 1'b0);
    checkOutput("lit reset arvalid", axi.m_arvalid, 1'b0);

    // Single-beat read for requester 0.
    applyStimulus(0, 2'b01, 1, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit accept0", reqAcc, 2'b01);
    checkOutput("lit idle busy", busy, 1'b0);
    applyStimulus(0, 2'b00, 1, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit araddr0", axi.m_araddr, ADDR0);
    checkOutput("lit arlen0", axi.m_arlen, 8'd0);
    checkOutput("lit arsize", axi.m_arsize, 3'b110);
    checkOutput("lit arvalid", axi.m_arvalid, 1'b1);
    applyStimulus(0, 2'b00, 0, 1, 1, 2'b00, mkData(1));
    @(negedge clk);
    checkOutput("lit rsp_vld0", rspVld, 2'b01);
    checkOutput("lit rsp_err0", rspErr, 1'b0);
    checkOutput("lit rsp_data0", rspData, mkData(1));
    applyStimulus(0, 2'b00, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit back idle", busy, 1'b0);

    // Both request together out of reset: 0 then 1, then 0 again.
    applyStimulus(1, 2'b00, 0, 0, 0, 2'b00, '0);
    applyStimulus(1, 2'b00, 0, 0, 0, 2'b00, '0);
    applyStimulus(0, 2'b11, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit both first", reqAcc, 2'b01);
    applyStimulus(0, 2'b10, 1, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit no acc in addr", reqAcc, 2'b00);
    applyStimulus(0, 2'b10, 0, 1, 1, 2'b00, mkData(2));
    @(negedge clk);
    checkOutput("lit beat owner0", rspVld, 2'b01);
    applyStimulus(0, 2'b10, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit second acc1", reqAcc, 2'b10);
    applyStimulus(0, 2'b00, 1, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit araddr1", axi.m_araddr, ADDR1);
    checkOutput("lit arlen1", axi.m_arlen, 8'd3);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(0, 2'b00, 0, 1, (b == 3), 2'b00, mkData(10 + b));
      @(negedge clk);
      checkOutput("lit beat owner1", rspVld, 2'b10);
      checkOutput("lit clean err", rspErr, 1'b0);
    end
    applyStimulus(0, 2'b11, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit wrap to 0", reqAcc, 2'b01);

    // AR stall: payload stable, other requester not accepted.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 2'b10, 0, 0, 0, 2'b00, '0);
      @(negedge clk);
      checkOutput("lit stall arvalid", axi.m_arvalid, 1'b1);
      checkOutput("lit stall araddr", axi.m_araddr, ADDR0);
      checkOutput("lit stall acc", reqAcc, 2'b00);
    end
    applyStimulus(0, 2'b10, 1, 0, 0, 2'b00, '0);
    applyStimulus(0, 2'b10, 0, 1, 1, 2'b00, mkData(20));

    // Error on last beat via rresp.
    applyStimulus(0, 2'b10, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit acc1 rresp", reqAcc, 2'b10);
    applyStimulus(0, 2'b00, 1, 0, 0, 2'b00, '0);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(0, 2'b00, 0, 1, (b == 3), (b == 3) ? 2'b10 : 2'b00, mkData(30 + b));
      @(negedge clk);
      checkOutput("lit rresp vld", rspVld, 2'b10);
      checkOutput("lit rresp err", rspErr, (b == 3));
    end

    // Early rlast on beat 2 of a 4-beat burst.
    applyStimulus(0, 2'b10, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit acc1 early", reqAcc, 2'b10);
    applyStimulus(0, 2'b00, 1, 0, 0, 2'b00, '0);
    applyStimulus(0, 2'b00, 0, 1, 0, 2'b00, mkData(40));
    @(negedge clk);
    checkOutput("lit early beat1 err", rspErr, 1'b0);
    applyStimulus(0, 2'b00, 0, 1, 1, 2'b00, mkData(41));
    @(negedge clk);
    checkOutput("lit early err", rspErr, 1'b1);
    checkOutput("lit early last", rspLast, 1'b1);
    applyStimulus(0, 2'b00, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit early idle", busy, 1'b0);

    // Overrun: len 0 burst gets an extra beat before rlast.
    applyStimulus(0, 2'b01, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit acc0 overrun", reqAcc, 2'b01);
    applyStimulus(0, 2'b00, 1, 0, 0, 2'b00, '0);
    applyStimulus(0, 2'b00, 0, 1, 0, 2'b00, mkData(50));
    @(negedge clk);
    checkOutput("lit overrun busy", busy, 1'b1);
    applyStimulus(0, 2'b00, 0, 1, 1, 2'b00, mkData(51));
    @(negedge clk);
    checkOutput("lit overrun err", rspErr, 1'b1);

    // R beats while idle are ignored.
    applyStimulus(0, 2'b00, 0, 1, 1, 2'b00, mkData(60));
    @(negedge clk);
    checkOutput("lit idle rvld", rspVld, 2'b00);
    checkOutput("lit idle rready", axi.m_rready, 1'b0);
    checkOutput("lit idle rdata", rspData, '0);

    // Reset mid-DATA, rr pointer returns to 0.
    applyStimulus(0, 2'b11, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit ptr1 acc", reqAcc, 2'b10);
    applyStimulus(0, 2'b01, 1, 0, 0, 2'b00, '0);
    applyStimulus(0, 2'b01, 0, 1, 0, 2'b00, mkData(70));
    @(negedge clk);
    checkOutput("lit pre-reset beat", rspVld, 2'b10);
    applyStimulus(1, 2'b01, 0, 0, 0, 2'b00, '0);
    applyStimulus(0, 2'b00, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit post-reset busy", busy, 1'b0);
    checkOutput("lit post-reset rready", axi.m_rready, 1'b0);
    checkOutput("lit post-reset arvalid", axi.m_arvalid, 1'b0);
    checkOutput("lit post-reset arburst", axi.m_arburst, 2'b00);
    applyStimulus(0, 2'b11, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit post-reset ptr0", reqAcc, 2'b01);
    applyStimulus(0, 2'b10, 1, 0, 0, 2'b00, '0);
    applyStimulus(0, 2'b10, 0, 1, 1, 2'b00, mkData(80));
    applyStimulus(0, 2'b10, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit post-reset acc1", reqAcc, 2'b10);
    applyStimulus(0, 2'b00, 1, 0, 0, 2'b00, '0);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(0, 2'b00, 0, 1, (b == 3), 2'b00, mkData(90 + b));
    end
    applyStimulus(0, 2'b00, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("lit final idle", busy, 1'b0);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/hawk_axi_rd_arb.md
HAWK_AXI_RD_ARB -- requirements
Module: hawk_axi_rd_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of read requesters; index 0 is the page manager, index 1 is the compression manager.
REQ-002 Parameter AW, default `HACD_AXI4_ADDR_WIDTH, AXI address width.
REQ-003 Parameter DW, default `HACD_AXI4_DATA_WIDTH (512), AXI data width.
REQ-004 clk_i  in  1  single clock.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 req_vld_i  in  NUM_REQ  per-requester read request valid; held until accepted.
REQ-007 req_addr_i  in  NUM_REQ*AW  per-requester cacheline address.
REQ-008 req_len_i  in  NUM_REQ*8  per-requester arlen.
REQ-009 req_acc_o  out  NUM_REQ  one-cycle accept pulse to the winning requester.
REQ-010 rsp_vld_o  out  NUM_REQ  per-requester data beat valid.
REQ-011 rsp_data_o, rsp_last_o, rsp_err_o  out  DW/1/1  shared response data, last beat, error on last beat.
REQ-012 m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid  out  AW/8/3/2/1  AXI AR channel; m_arready in 1.
REQ-013 m_rdata, m_rresp, m_rlast, m_rvalid  in  DW/2/1/1  AXI R channel; m_rready out 1.
REQ-014 busy_o  out  1  high whenever the FSM is not IDLE.

Function
REQ-015 FSM states are IDLE, ADDR and DATA; exactly one transaction is outstanding at a time.
REQ-016 IDLE: when any req_vld_i is set, the arbiter picks a winner round-robin starting at rr_ptr, latches its addr/len/index, pulses req_acc_o[winner] in the same cycle, and moves to ADDR.
REQ-017 ADDR: m_arvalid=1 with the latched addr/len, m_arsize=3'b110, m_arburst=2'b01 (INCR); the FSM moves to DATA on m_arvalid&&m_arready, and the AR payload stays stable while stalled.
REQ-018 Latency: m_arvalid rises in the cycle after req_acc_o.
REQ-019 DATA: m_rready=1; each m_rvalid beat passes through combinationally to rsp_vld_o[owner] with rsp_data_o=m_rdata and rsp_last_o=m_rlast.
REQ-020 The 8-bit beat counter increments per beat and clears on entry to ADDR.
REQ-021 rsp_err_o is asserted with the last beat if any beat had m_rresp[1]=1, or if m_rlast arrived when count!=latched len.
REQ-022 If count exceeds len without m_rlast, the error is flagged sticky and the FSM keeps waiting for m_rlast.
REQ-023 On the m_rlast beat, rr_ptr becomes (owner+1) mod NUM_REQ and the FSM returns to IDLE; no new accept occurs in the same cycle.
REQ-024 m_rvalid outside DATA is ignored (m_rready=0); rsp_vld_o stays 0.
REQ-025 A requester dropping req_vld_i before accept is simply not granted; the block takes no action on it after accept.
REQ-026 rsp_data_o is 0 when no rsp_vld_o bit is set.

Reset
REQ-027 rst_i forces state=IDLE, rr_ptr=0, count=0, sticky error=0, and all outputs to 0 (m_arsize/m_arburst to 0) on the next edge, including mid-ADDR or mid-DATA.
REQ-028 After reset, the AXI slave is not waited on; an aborted transaction is the system's responsibility.

Structure
REQ-029 The arb FSM state enum and requester index constants (RD_REQ_PGMNGR=0, RD_REQ_CMPMNGR=1) SHALL live in hawk_rd_pkg.
REQ-030 The round-robin picker SHALL be a sub-module hawk_rr_arb (inputs req, ptr; outputs one-hot grant and index).

Verification
REQ-031 req_vld_i=01, addr0=0x8000_0040, len=0, arready=1 -> req_acc_o=01, next cycle araddr=0x8000_0040, arlen=0; one beat with rlast gives rsp_vld_o=01, rsp_err_o=0.
REQ-032 req_vld_i=11 together out of reset -> requester 0 is served first, then 1; after both, requester 0 is served first again only when rr_ptr=0.
REQ-033 arready held 0 for 5 cycles -> araddr/arlen stay stable, arvalid stays 1, and no accept goes to the other requester.
REQ-034 len=3, 4 beats, last beat rresp=2'b10 -> 4 rsp_vld pulses to the owner; rsp_err_o=1 only on the 4th.
REQ-035 len=3, rlast on beat 2 -> rsp_err_o=1 with rsp_last_o, and the FSM is IDLE in the next cycle.
REQ-036 rst_i asserted mid-DATA -> next cycle all outputs are 0, state is IDLE, and a new req_vld_i=10 is granted to requester 1's index only per rr_ptr=0 order.
